// File: rtl/slow_access_timer.sv
// Holds the accelerator in slow mode during accesses to slow-enabled devices and for a
// programmable number of prescaled ticks after each such bus cycle ends.
module slow_access_timer #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned PS_W     = 10
) (
    input  logic       CLK,
    input  logic       POR,
    input  logic       BACT,
    input  logic       IACKCS,
    input  logic       VIACS,
    input  logic       IWMCS,
    input  logic       SCCCS,
    input  logic       SCSICS,
    input  logic       SndCS,
    input  logic       SlowIACK,
    input  logic       SlowVIA,
    input  logic       SlowIWM,
    input  logic       SlowSCC,
    input  logic       SlowSCSI,
    input  logic       SlowSnd,
    input  logic       SlowClockGate,
    input  logic [3:0] SlowTimeout,
    output logic       Slow,
    output logic       ClockGate,
    output logic [3:0] Remaining
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StHold   = 2'd2
    } fsmState;

    localparam logic [PS_W-1:0] PsLast = PS_W'(PRESCALE - 1);

    fsmState          stateQ, stateD;
    logic [3:0]       cntQ, cntD;
    logic [PS_W-1:0]  psQ, psD;
    logic             bactR;
    logic             slowReq;
    logic             start;
    logic             tick;

    assign slowReq = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
                     (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd);
    assign start   = BACT & ~bactR;
    assign tick    = (psQ == PsLast);

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        psD    = psQ;
        case (stateQ)
            StIdle: begin
                if (start && slowReq) begin
                    stateD = StAccess;
                end
            end
            StAccess: begin
                if (!BACT) begin
                    if (SlowTimeout == 4'd0) begin
                        stateD = StIdle;
                    end else begin
                        stateD = StHold;
                        cntD   = SlowTimeout;
                        psD    = '0;
                    end
                end
            end
            StHold: begin
                // A new slow access pre-empts the hold, even on the expiring tick.
                if (start && slowReq) begin
                    stateD = StAccess;
                end else begin
                    psD = tick ? '0 : psQ + PS_W'(1);
                    if (tick) begin
                        cntD = cntQ - 4'd1;
                        if (cntQ == 4'd1) begin
                            stateD = StIdle;
                        end
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (POR) begin
            stateQ    <= StIdle;
            cntQ      <= '0;
            psQ       <= '0;
            bactR     <= 1'b0;
            Slow      <= 1'b0;
            ClockGate <= 1'b0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            psQ       <= psD;
            bactR     <= BACT;
            Slow      <= (stateD != StIdle);
            ClockGate <= SlowClockGate & (stateD != StIdle);
        end
    end

    assign Remaining = (stateQ == StHold) ? cntQ : 4'd0;

endmodule

// File: tb/tb_slow_access_timer.sv
// Randomized and directed bench for slow_access_timer against a cycle-countdown model.
module tb_slow_access_timer;

    localparam int P  = 5;
    localparam int PW = 3;

    logic       CLK = 1'b0;
    logic       POR;
    logic       BACT;
    logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
    logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
    logic       SlowClockGate;
    logic [3:0] SlowTimeout;
    logic       Slow;
    logic       ClockGate;
    logic [3:0] Remaining;

    int checks = 0;
    int errors = 0;

    // Model: slow while in a slow access, or while holdLeft (in CLK cycles) is nonzero.
    bit         mBactPrev;
    bit         mInAccess;
    int         mHold;
    bit         mSlow;
    bit         mGate;
    logic [3:0] mRem;

    slow_access_timer #(.PRESCALE(P), .PS_W(PW)) dut (
        .CLK(CLK), .POR(POR), .BACT(BACT),
        .IACKCS(IACKCS), .VIACS(VIACS), .IWMCS(IWMCS), .SCCCS(SCCCS),
        .SCSICS(SCSICS), .SndCS(SndCS),
        .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM), .SlowSCC(SlowSCC),
        .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd), .SlowClockGate(SlowClockGate),
        .SlowTimeout(SlowTimeout), .Slow(Slow), .ClockGate(ClockGate),
        .Remaining(Remaining)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        POR = 0; BACT = 0;
        {IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS} = '0;
        {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = '0;
        SlowClockGate = 0; SlowTimeout = 0;
    endtask

    // Advance one clock edge, update the model, and return at the following negedge.
    task automatic step();
        bit req, start;
        @(posedge CLK);
        req = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
              (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd);
        start = BACT && !mBactPrev;
        if (POR) begin
            mInAccess = 0;
            mHold     = 0;
            mBactPrev = 0;
        end else begin
            if (mInAccess) begin
                if (!BACT) begin
                    mInAccess = 0;
                    mHold     = int'(SlowTimeout) * P;
                end
            end else if (start && req) begin
                mInAccess = 1;
                mHold     = 0;
            end else if (mHold > 0) begin
                mHold--;
            end
            mBactPrev = BACT;
        end
        mSlow = !POR && (mInAccess || mHold > 0);
        mGate = mSlow && SlowClockGate;
        mRem  = mInAccess ? 4'd0 : 4'((mHold + P - 1) / P);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        clear_inputs();
        POR = 1; BACT = 1; VIACS = 1; SlowVIA = 1;
        step();
        step();
        checks++;
        if (Slow !== 1'b0 || ClockGate !== 1'b0 || Remaining !== 4'd0) begin
            errors++;
            $display("FAIL reset: Slow=%b ClockGate=%b Remaining=%0d, want 0 0 0",
                     Slow, ClockGate, Remaining);
        end
        BACT = 0; VIACS = 0;
        step();
        POR = 0;
        step();
        checks++;
        if (Slow !== mSlow || ClockGate !== mGate || Remaining !== mRem) begin
            errors++;
            $display("FAIL reset_release: got %b %b %0d want %b %b %0d",
                     Slow, ClockGate, Remaining, mSlow, mGate, mRem);
        end
    endtask

    task automatic test_via_access();
        int highCount = 0;
        logic [3:0] lastRem = 4'd0;
        int remSeq[$];
        clear_inputs();
        SlowVIA = 1; SlowTimeout = 3; VIACS = 1; BACT = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (Slow !== 1'b1 || Remaining !== 4'd0 || Slow !== mSlow) begin
                errors++;
                $display("FAIL via_access: cyc %0d Slow=%b Remaining=%0d want 1 0", i, Slow,
                         Remaining);
            end
        end
        BACT = 0; VIACS = 0;
        for (int i = 0; i < 3 * P + 3; i++) begin
            step();
            if (i == 2) SlowTimeout = 4'd9;
            if (Slow === 1'b1) highCount++;
            if (Remaining !== lastRem && Remaining !== 4'd0) remSeq.push_back(int'(Remaining));
            lastRem = Remaining;
            checks++;
            if (Slow !== mSlow || ClockGate !== mGate || Remaining !== mRem) begin
                errors++;
                $display("FAIL via_hold: cyc %0d got %b %b %0d want %b %b %0d", i,
                         Slow, ClockGate, Remaining, mSlow, mGate, mRem);
            end
        end
        checks++;
        if (highCount !== 3 * P) begin
            errors++;
            $display("FAIL via_hold_len: got %0d cycles want %0d", highCount, 3 * P);
        end
        checks++;
        if (remSeq.size() != 3 || remSeq[0] != 3 || remSeq[1] != 2 || remSeq[2] != 1) begin
            errors++;
            $display("FAIL via_remaining_seq: got %p want 3,2,1", remSeq);
        end
    endtask

    task automatic test_disabled();
        clear_inputs();
        SlowVIA = 1; SlowIWM = 1; SlowTimeout = 5; SCCCS = 1; BACT = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin BACT = 0; SCCCS = 0; end
            step();
            checks++;
            if (Slow !== 1'b0 || Remaining !== 4'd0 || Slow !== mSlow) begin
                errors++;
                $display("FAIL disabled: cyc %0d Slow=%b Remaining=%0d want 0 0", i, Slow,
                         Remaining);
            end
        end
    endtask

    task automatic test_zero_timeout();
        clear_inputs();
        SlowIWM = 1; SlowTimeout = 0; IWMCS = 1; BACT = 1;
        for (int i = 0; i < 3; i++) step();
        BACT = 0; IWMCS = 0;
        step();
        checks++;
        if (Slow !== 1'b0 || Slow !== mSlow) begin
            errors++;
            $display("FAIL zero_timeout_fall: Slow=%b want 0", Slow);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (Slow !== 1'b0 || Remaining !== 4'd0) begin
                errors++;
                $display("FAIL zero_timeout_idle: Slow=%b Remaining=%0d want 0 0", Slow,
                         Remaining);
            end
        end
    endtask

    task automatic test_retrigger();
        int guard = 0;
        clear_inputs();
        SlowSCSI = 1; SlowTimeout = 2; SCSICS = 1; BACT = 1;
        step(); step();
        BACT = 0; SCSICS = 0;
        step();
        while (mRem != 4'd1 && guard < 4 * P) begin
            step();
            guard++;
        end
        checks++;
        if (Remaining !== 4'd1) begin
            errors++;
            $display("FAIL retrigger_wait: Remaining=%0d want 1", Remaining);
        end
        SlowTimeout = 4; SCSICS = 1; BACT = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (Slow !== 1'b1 || Remaining !== 4'd0) begin
                errors++;
                $display("FAIL retrigger_access: Slow=%b Remaining=%0d want 1 0", Slow,
                         Remaining);
            end
        end
        BACT = 0; SCSICS = 0;
        step();
        checks++;
        if (Remaining !== 4'd4 || Slow !== 1'b1) begin
            errors++;
            $display("FAIL retrigger_reload: Remaining=%0d Slow=%b want 4 1", Remaining, Slow);
        end
        for (int i = 0; i < 4 * P + 2; i++) begin
            step();
            checks++;
            if (Slow !== mSlow || Remaining !== mRem) begin
                errors++;
                $display("FAIL retrigger_hold: cyc %0d got %b %0d want %b %0d", i, Slow,
                         Remaining, mSlow, mRem);
            end
        end
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        clear_inputs();
        SlowIACK = 1; SlowTimeout = 1; IACKCS = 1; BACT = 1;
        step();
        BACT = 0; IACKCS = 0;
        step();
        // Raise a new slow access so it starts on the very edge the hold expires.
        while (mHold != 1 && guard < 2 * P) begin
            step();
            guard++;
        end
        IACKCS = 1; BACT = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (Slow !== 1'b1 || Slow !== mSlow || Remaining !== 4'd0) begin
                errors++;
                $display("FAIL back_to_back: cyc %0d Slow=%b Remaining=%0d want 1 0", i,
                         Slow, Remaining);
            end
        end
        BACT = 0; IACKCS = 0;
        for (int i = 0; i < P + 2; i++) step();
    endtask

    task automatic test_gate_reset();
        clear_inputs();
        SlowClockGate = 1; SlowSnd = 1; SlowTimeout = 3; SndCS = 1; BACT = 1;
        step(); step();
        BACT = 0; SndCS = 0;
        for (int i = 0; i < P + 2; i++) begin
            step();
            checks++;
            if (ClockGate !== 1'b1 || Slow !== 1'b1 || ClockGate !== mGate) begin
                errors++;
                $display("FAIL gate_hold: cyc %0d ClockGate=%b Slow=%b want 1 1", i,
                         ClockGate, Slow);
            end
        end
        POR = 1;
        step();
        POR = 0;
        checks++;
        if (ClockGate !== 1'b0 || Slow !== 1'b0 || Remaining !== 4'd0) begin
            errors++;
            $display("FAIL gate_por: ClockGate=%b Slow=%b Remaining=%0d want 0 0 0",
                     ClockGate, Slow, Remaining);
        end
        step();
        checks++;
        if (Slow !== mSlow || ClockGate !== mGate || Remaining !== mRem) begin
            errors++;
            $display("FAIL gate_after_por: got %b %b %0d want %b %b %0d", Slow, ClockGate,
                     Remaining, mSlow, mGate, mRem);
        end
    endtask

    task automatic test_random();
        logic [5:0] cs;
        logic [5:0] en;
        int gap, len;
        clear_inputs();
        for (int t = 0; t < 40; t++) begin
            gap = $urandom_range(0, 4 * P);
            for (int g = 0; g < gap; g++) begin
                POR = ($urandom_range(0, 99) == 0);
                if ($urandom_range(0, 9) == 0) SlowTimeout = 4'($urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) begin
                    en = 6'($urandom_range(0, 63));
                    {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = en;
                end
                step();
                checks++;
                if (Slow !== mSlow || ClockGate !== mGate || Remaining !== mRem) begin
                    errors++;
                    $display("FAIL random_gap: t %0d got %b %b %0d want %b %b %0d", t,
                             Slow, ClockGate, Remaining, mSlow, mGate, mRem);
                end
            end
            POR = 0;
            cs = 6'($urandom_range(0, 63));
            en = 6'($urandom_range(0, 63));
            {IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS} = cs;
            {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = en;
            SlowTimeout = 4'($urandom_range(0, 3));
            SlowClockGate = 1'($urandom_range(0, 1));
            BACT = 1;
            len = $urandom_range(1, 4);
            for (int l = 0; l < len; l++) begin
                step();
                checks++;
                if (Slow !== mSlow || ClockGate !== mGate || Remaining !== mRem) begin
                    errors++;
                    $display("FAIL random_access: t %0d got %b %b %0d want %b %b %0d", t,
                             Slow, ClockGate, Remaining, mSlow, mGate, mRem);
                end
            end
            BACT = 0;
            {IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS} = '0;
        end
    endtask

    initial begin
        mBactPrev = 0; mInAccess = 0; mHold = 0; mSlow = 0; mGate = 0; mRem = 0;
        clear_inputs();
        @(negedge CLK);
        test_reset();
        test_via_access();
        test_disabled();
        test_zero_timeout();
        test_retrigger();
        test_back_to_back();
        test_gate_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
